regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-data path.
REQ-002 Parameter ADDR_W, default 3, register-address width; 2**ADDR_W registers are tracked (8 by default).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_addr  in  ADDR_W  ALU destination register.
REQ-007 alu_data  in  DATA_W  ALU result.
REQ-008 alu_ready  out  1  ALU request accepted this cycle.
REQ-009 mem_valid / mem_addr / mem_data  in  1 / ADDR_W / DATA_W  load-unit writeback request, same meaning as the ALU ports.
REQ-010 mem_ready  out  1  MEM request accepted this cycle.
REQ-011 claim_valid  in  1  issue stage reserves a destination register.
REQ-012 claim_addr  in  ADDR_W  register being reserved.
REQ-013 rf_we  out  1  register-file write enable, registered.
REQ-014 rf_wa  out  ADDR_W  register-file write address, registered.
REQ-015 rf_wd  out  DATA_W  register-file write data, registered.
REQ-016 busy  out  2**ADDR_W  per-register pending-write flags, registered.

Function
REQ-017 Requests SHALL use a valid/ready handshake; a transfer occurs in a cycle where valid and ready are both 1.
REQ-018 ready outputs SHALL be combinational from valid, the priority pointer and reset; the two ready signals SHALL never be 1 in the same cycle.
REQ-019 With only one valid requester, that requester SHALL be granted in the same cycle.
REQ-020 With both valid, grant SHALL go to the requester not granted most recently (round-robin pointer, 1 bit).
REQ-021 The pointer SHALL update only on a transfer.
REQ-022 An ungranted requester SHALL hold valid, addr and data stable until granted.
REQ-023 Registering the transfer: rf_we=1, rf_wa=addr and rf_wd=data SHALL appear on the rising edge after the transfer (latency 1).
REQ-024 rf_we SHALL be 0 in any cycle following a cycle without a transfer; rf_wa and rf_wd hold their last values.
REQ-025 Outputs SHALL be stable from the rising edge onward, so the register file's falling-edge write captures them half a cycle later.
REQ-026 Throughput SHALL be one write per cycle; the register file never back-pressures.
REQ-027 Scoreboard set: claim_valid with claim_addr=a SHALL set busy[a] on the next rising edge.
REQ-028 Scoreboard clear: a transfer to address a SHALL clear busy[a] on the same edge that asserts rf_we.
REQ-029 Simultaneous claim and transfer to the same address: set SHALL win and busy stays 1.
REQ-030 Claim of an already-busy register: busy stays 1 and clears at the next write to it, with no counting.
REQ-031 A transfer to a non-busy register SHALL still be written; busy is unchanged.
REQ-032 The top address (2**ADDR_W-1, the PC alias): claims SHALL be ignored and busy for that address SHALL read 0.
REQ-033 Writes to the top address SHALL be forwarded to the register file like any other address.
REQ-034 Claims and transfers to different addresses in the same cycle SHALL both take effect.

Reset
REQ-035 While reset=0: alu_ready=0, mem_ready=0, rf_we=0, rf_wa=0, rf_wd=0, busy=0.
REQ-036 While reset=0 the pointer SHALL be set so the ALU wins the first contention.
REQ-037 Assertion mid-operation SHALL discard any in-flight registered write, so rf_we drops immediately without waiting for a clock edge.
REQ-038 The first transfer SHALL be possible in the first cycle after deassertion.

Verification
REQ-039 Scenario, ALU alone: alu_valid=1, addr=3, data=0xDEADBEEF, for one cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-040 Scenario, contention after reset: ALU (addr 1, 0x11) and MEM (addr 2, 0x22) valid for 3 cycles -> grants ALU then MEM; rf writes (1,0x11) then (2,0x22); each ready high exactly once.
REQ-041 Scenario, scoreboard: claim addr 5, then 3 idle cycles, then MEM write to addr 5 -> busy[5] goes 1 the cycle after the claim and 0 on the edge where rf_we=1, rf_wa=5.
REQ-042 Scenario, claim/write collision: claim addr 4 and ALU write to addr 4 in the same cycle, with busy[4] previously 1 -> busy[4] remains 1 and rf_we=1, rf_wa=4.
REQ-043 Scenario, top address: claim addr 7 -> busy stays 0x00; ALU write to addr 7 with 0x55 -> rf_we=1, rf_wa=7, rf_wd=0x55.
REQ-044 Scenario, reset mid-stream: reset low between clock edges while rf_we=1 and busy=0x0C -> rf_we=0 and busy=0x00 immediately; after release, contention grants ALU first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates two writeback sources (ALU and load unit) onto the single write
// port of a register file. It also keeps a per-register pending-write
// scoreboard that the issue stage sets when it reserves a destination and a
// writeback clears.
//
// Handshake: a request is presented with valid high plus stable addr/data.
// It transfers in the cycle where valid and ready are both 1. A requester that
// is not granted keeps valid, addr and data unchanged until it sees ready.
// ready is combinational from both valids, the round-robin pointer and reset.
// At most one ready is high in any cycle. The register file never stalls, so
// one write can complete every cycle.
//
// Ports
//   clk          in   clock, rising-edge state updates
//   reset        in   asynchronous, active-low reset
//   alu_valid    in   ALU writeback request
//   alu_addr     in   ALU destination register
//   alu_data     in   ALU result
//   alu_ready    out  ALU request accepted this cycle
//   mem_valid    in   load-unit writeback request
//   mem_addr     in   load-unit destination register
//   mem_data     in   load-unit data
//   mem_ready    out  load-unit request accepted this cycle
//   claim_valid  in   issue stage reserves a destination register
//   claim_addr   in   register being reserved
//   rf_we        out  registered register-file write enable
//   rf_wa        out  registered register-file write address
//   rf_wd        out  registered register-file write data
//   busy         out  registered per-register pending-write flags
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_wa,
  output logic [DATA_W-1:0]      rf_wd,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int                NREG     = 2**ADDR_W;
  // The top register aliases the PC. It is never tracked as pending.
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NREG - 1);

  // mem_prio_q = 1: the load unit wins the next contention, which means the
  // ALU was granted most recently. Reset clears it so the ALU wins first.
  logic              mem_prio_q, mem_prio_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              alu_grant;
  logic              mem_grant;
  logic              xfer;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // ---------------------------------------------------------------------------
  // Grant logic. This is purely combinational, so a lone requester is granted
  // in the same cycle. The reset term forces both readies low while reset is
  // held, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (reset) begin
      if (alu_valid && mem_valid) begin
        alu_grant = ~mem_prio_q;
        mem_grant = mem_prio_q;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign xfer      = alu_grant | mem_grant;

  // Write-path mux: the grants are one-hot, so the load-unit grant selects.
  always_comb begin
    wr_addr = alu_addr;
    wr_data = alu_data;
    if (mem_grant) begin
      wr_addr = mem_addr;
      wr_data = mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_prio_d = mem_prio_q;
    // The pointer moves only on a transfer. After an ALU grant the load unit
    // is preferred. After a load-unit grant the ALU is preferred.
    if (xfer) begin
      mem_prio_d = alu_grant;
    end
  end

  always_comb begin
    rf_we_d = xfer;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    // Address and data hold their last values when no write happens.
    if (xfer) begin
      rf_wa_d = wr_addr;
      rf_wd_d = wr_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    // The clear is applied before the set, so a claim and a writeback to the
    // same register in one cycle leave it busy. The new producer is still
    // outstanding. A re-claim of a busy register is a plain set, with no
    // counting.
    if (xfer) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_valid) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[TOP_ADDR] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers. The asynchronous reset drops rf_we immediately. This
  // discards any write still waiting for the register file's falling-edge
  // capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_prio_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      busy_q     <= '0;
    end else begin
      mem_prio_q <= mem_prio_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  typedef struct packed {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          cv;
    logic [AW-1:0] ca;
  } stim_t;

  typedef struct packed {
    logic          ar;
    logic          mr;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NR-1:0] busy;
  } obs_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          claim_valid = 1'b0;
  logic [AW-1:0] claim_addr = '0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model: the grant rule plus a queue of expected register-file
  // writes and an array of pending flags
  // ---------------------------------------------------------------------------
  logic [AW+DW-1:0] exp_q[$];
  bit               m_alu_last;
  bit               m_busy[NR];
  logic             m_we;
  logic [AW-1:0]    m_wa;
  logic [DW-1:0]    m_wd;

  task automatic model_reset();
    exp_q.delete();
    m_alu_last = 1'b0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic model_step(input stim_t s, output obs_t e);
    int               g;
    int               ca_i;
    logic [AW+DW-1:0] w;
    g = 0;
    if (s.av && s.mv) g = m_alu_last ? 2 : 1;
    else if (s.av)    g = 1;
    else if (s.mv)    g = 2;
    e.ar = (g == 1);
    e.mr = (g == 2);
    if (g == 1) begin exp_q.push_back({s.aa, s.ad}); m_alu_last = 1'b1; end
    if (g == 2) begin exp_q.push_back({s.ma, s.md}); m_alu_last = 1'b0; end
    // Clock edge: the write issued this cycle appears on the register file.
    if (exp_q.size() > 0) begin
      w    = exp_q.pop_front();
      m_we = 1'b1;
      m_wa = w[AW+DW-1:DW];
      m_wd = w[DW-1:0];
      m_busy[int'(m_wa)] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    ca_i = int'(s.ca);
    if (s.cv && ca_i != NR - 1) m_busy[ca_i] = 1'b1;
    e.we = m_we;
    e.wa = m_wa;
    e.wd = m_wd;
    for (int i = 0; i < NR; i++) e.busy[i] = m_busy[i];
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic stim_t mk(input logic av, input int aa, input logic [DW-1:0] ad,
                               input logic mv, input int ma, input logic [DW-1:0] md,
                               input logic cv, input int ca);
    stim_t s;
    s.av = av; s.aa = AW'(aa); s.ad = ad;
    s.mv = mv; s.ma = AW'(ma); s.md = md;
    s.cv = cv; s.ca = AW'(ca);
    return s;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ar=%b mr=%b we=%b wa=%0d wd=%h busy=%h",
                     o.ar, o.mr, o.we, o.wa, o.wd, o.busy);
  endfunction

  // Inputs are driven at the falling edge. ready is sampled just after, and
  // the registered outputs are sampled 1ns after the rising edge.
  task automatic run(input stim_t s, output obs_t o, output obs_t e);
    @(negedge clk);
    alu_valid = s.av; alu_addr = s.aa; alu_data = s.ad;
    mem_valid = s.mv; mem_addr = s.ma; mem_data = s.md;
    claim_valid = s.cv; claim_addr = s.ca;
    #1;
    o.ar = alu_ready;
    o.mr = mem_ready;
    @(posedge clk);
    #1;
    o.we = rf_we; o.wa = rf_wa; o.wd = rf_wd; o.busy = busy;
    model_step(s, e);
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    alu_valid = 1'b1; mem_valid = 1'b1; claim_valid = 1'b1; claim_addr = 3'd2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got alu=%b mem=%b, required 0 0", alu_ready, mem_ready);
    end
    n_vec++;
    if (rf_we !== 1'b0 || rf_wa !== '0 || rf_wd !== '0) begin
      n_err++;
      $display("FAIL reset_rf: got we=%b wa=%0d wd=%h, required 0 0 0", rf_we, rf_wa, rf_wd);
    end
    n_vec++;
    if (busy !== '0) begin
      n_err++;
      $display("FAIL reset_busy: got %h, required 00", busy);
    end
    do_reset();
  endtask

  task automatic test_alu_alone();
    obs_t o, e;
    obs_t oo[2];
    run(mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0), o, e);
    oo[0] = o;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL alu_alone c0: got %s required %s", fmt(o), fmt(e)); end
    run(mk(0, 0, 0, 0, 0, 0, 0, 0), o, e);
    oo[1] = o;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL alu_alone c1: got %s required %s", fmt(o), fmt(e)); end
    n_vec++;
    if (oo[0].ar !== 1'b1 || oo[0].we !== 1'b1 || oo[0].wa !== 3'd3 || oo[0].wd !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL alu_alone_fixed: got %s required ar=1 we=1 wa=3 wd=deadbeef", fmt(oo[0]));
    end
    n_vec++;
    if (oo[1].we !== 1'b0) begin
      n_err++;
      $display("FAIL alu_alone_we_drop: got we=%b required 0", oo[1].we);
    end
  endtask

  task automatic test_contention();
    obs_t  o, e;
    stim_t s;
    int    alu_cnt, mem_cnt;
    do_reset();
    s = mk(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
    alu_cnt = 0; mem_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      run(s, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL contention c%0d: got %s required %s", c, fmt(o), fmt(e)); end
      alu_cnt += int'(o.ar);
      mem_cnt += int'(o.mr);
      n_vec++;
      if (c == 0 && (o.ar !== 1'b1 || o.wa !== 3'd1 || o.wd !== 32'h11)) begin
        n_err++; $display("FAIL contention_first: got %s required ar=1 wa=1 wd=11", fmt(o));
      end else if (c == 1 && (o.mr !== 1'b1 || o.wa !== 3'd2 || o.wd !== 32'h22)) begin
        n_err++; $display("FAIL contention_second: got %s required mr=1 wa=2 wd=22", fmt(o));
      end else if (c == 2 && o.we !== 1'b0) begin
        n_err++; $display("FAIL contention_idle: got we=%b required 0", o.we);
      end
      if (e.ar) s.av = 1'b0;
      if (e.mr) s.mv = 1'b0;
    end
    n_vec++;
    if (alu_cnt != 1 || mem_cnt != 1) begin
      n_err++;
      $display("FAIL contention_count: got alu=%0d mem=%0d required 1 1", alu_cnt, mem_cnt);
    end
  endtask

  task automatic test_top_addr();
    obs_t o, e;
    run(mk(0, 0, 0, 0, 0, 0, 1, 7), o, e);
    n_vec++;
    if (o !== e || o.busy !== 8'h00) begin
      n_err++; $display("FAIL top_claim: got %s required %s", fmt(o), fmt(e));
    end
    run(mk(1, 7, 32'h55, 0, 0, 0, 0, 0), o, e);
    n_vec++;
    if (o !== e || o.we !== 1'b1 || o.wa !== 3'd7 || o.wd !== 32'h55) begin
      n_err++; $display("FAIL top_write: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_scoreboard();
    obs_t o, e;
    run(mk(0, 0, 0, 0, 0, 0, 1, 5), o, e);
    n_vec++;
    if (o !== e || o.busy[5] !== 1'b1) begin
      n_err++; $display("FAIL sb_claim: got %s required %s", fmt(o), fmt(e));
    end
    for (int c = 0; c < 3; c++) begin
      run(mk(0, 0, 0, 0, 0, 0, 0, 0), o, e);
      n_vec++;
      if (o !== e || o.busy[5] !== 1'b1) begin
        n_err++; $display("FAIL sb_hold c%0d: got %s required %s", c, fmt(o), fmt(e));
      end
    end
    run(mk(0, 0, 0, 1, 5, 32'hA5A5_0005, 0, 0), o, e);
    n_vec++;
    if (o !== e || o.busy[5] !== 1'b0 || o.we !== 1'b1 || o.wa !== 3'd5) begin
      n_err++; $display("FAIL sb_clear: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_collision();
    obs_t o, e;
    run(mk(0, 0, 0, 0, 0, 0, 1, 4), o, e);
    n_vec++;
    if (o !== e || o.busy[4] !== 1'b1) begin
      n_err++; $display("FAIL coll_pre: got %s required %s", fmt(o), fmt(e));
    end
    run(mk(1, 4, 32'h4444, 0, 0, 0, 1, 4), o, e);
    n_vec++;
    if (o !== e || o.busy[4] !== 1'b1 || o.we !== 1'b1 || o.wa !== 3'd4) begin
      n_err++; $display("FAIL coll_same: got %s required %s", fmt(o), fmt(e));
    end
    // A second claim of a busy register is not counted: one write clears it.
    run(mk(1, 4, 32'h4445, 0, 0, 0, 0, 0), o, e);
    n_vec++;
    if (o !== e || o.busy[4] !== 1'b0) begin
      n_err++; $display("FAIL coll_clear: got %s required %s", fmt(o), fmt(e));
    end
    // A claim and a write to different registers in the same cycle both apply.
    run(mk(0, 0, 0, 1, 1, 32'h0101, 1, 6), o, e);
    n_vec++;
    if (o !== e || o.busy[6] !== 1'b1 || o.wa !== 3'd1) begin
      n_err++; $display("FAIL coll_diff: got %s required %s", fmt(o), fmt(e));
    end
    run(mk(1, 6, 32'h0606, 0, 0, 0, 0, 0), o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL coll_diff_clr: got %s required %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_midstream();
    obs_t o, e;
    run(mk(0, 0, 0, 0, 0, 0, 1, 2), o, e);
    run(mk(0, 0, 0, 0, 0, 0, 1, 3), o, e);
    run(mk(1, 0, 32'hCAFE, 0, 0, 0, 0, 0), o, e);
    n_vec++;
    if (o !== e || o.we !== 1'b1 || o.busy !== 8'h0C) begin
      n_err++; $display("FAIL mid_setup: got %s required %s", fmt(o), fmt(e));
    end
    // Reset between edges, with a request still valid.
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (rf_we !== 1'b0 || busy !== 8'h00 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got we=%b busy=%h ar=%b mr=%b required 0 00 0 0",
               rf_we, busy, alu_ready, mem_ready);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(mk(1, 1, 32'h77, 1, 2, 32'h88, 0, 0), o, e);
    n_vec++;
    if (o !== e || o.ar !== 1'b1 || o.mr !== 1'b0 || o.we !== 1'b1 || o.wa !== 3'd1) begin
      n_err++; $display("FAIL mid_after: got %s required %s", fmt(o), fmt(e));
    end
    run(mk(0, 1, 32'h77, 1, 2, 32'h88, 0, 0), o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL mid_after2: got %s required %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    obs_t  o, e;
    stim_t s;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      // A pending request is held unchanged until the model grants it.
      if (!s.av && $urandom_range(0, 3) != 0) begin
        s.av = 1'b1; s.aa = AW'($urandom_range(0, NR - 1)); s.ad = $urandom;
      end
      if (!s.mv && $urandom_range(0, 3) != 0) begin
        s.mv = 1'b1; s.ma = AW'($urandom_range(0, NR - 1)); s.md = $urandom;
      end
      s.cv = ($urandom_range(0, 2) == 0);
      s.ca = AW'($urandom_range(0, NR - 1));
      run(s, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random c%0d: got %s required %s", c, fmt(o), fmt(e)); end
      if (e.ar) s.av = 1'b0;
      if (e.mr) s.mv = 1'b0;
    end
    s.cv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run(s, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random_drain c%0d: got %s required %s", c, fmt(o), fmt(e)); end
      if (e.ar) s.av = 1'b0;
      if (e.mr) s.mv = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    test_reset();
    test_alu_alone();
    test_contention();
    test_top_addr();
    test_scoreboard();
    test_collision();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached before the test sequence ended");
    $fatal(1, "timeout");
  end

endmodule
